// File: rtl/schedule_1.sv
// schedule_1: first scheduler stage. Tracks outstanding register and CSR
// writes, stalls the front end on RAW/WAW/CSR hazards and registers hazard-free
// instructions for scheduler 2.
module schedule_1 #(
    parameter bit CSR_TRACK = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FLUSH,
    input  logic        MEM_WAIT,
    input  logic [31:0] CHECK_PC,
    input  logic [16:0] CHECK_OPCODE,
    input  logic [4:0]  CHECK_RD,
    input  logic [4:0]  CHECK_RS1,
    input  logic [4:0]  CHECK_RS2,
    input  logic [11:0] CHECK_CSR,
    input  logic [31:0] CHECK_IMM,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_RD,
    input  logic        WB_CSR_VALID,
    output logic        STALL,
    output logic        SCHEDULE1_VALID,
    output logic [31:0] SCHEDULE1_PC,
    output logic [16:0] SCHEDULE1_OPCODE,
    output logic [4:0]  SCHEDULE1_RD,
    output logic [4:0]  SCHEDULE1_RS1,
    output logic [4:0]  SCHEDULE1_RS2,
    output logic [11:0] SCHEDULE1_CSR,
    output logic [31:0] SCHEDULE1_IMM
);

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] pending;
    logic        csr_pending;

    logic        valid;
    logic        is_csr;
    logic [31:0] wb_mask;
    logic [31:0] set_mask;
    logic [31:0] eff;
    logic        eff_csr;
    logic        hazard;

    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [16:0] opcode_p1;
    logic [4:0]  rd_p1;
    logic [4:0]  rs1_p1;
    logic [4:0]  rs2_p1;
    logic [11:0] csr_p1;
    logic [31:0] imm_p1;

    // Decode, same-cycle writeback bypass of the scoreboard, and hazard detection
    always_comb begin
        valid    = (CHECK_OPCODE != 17'd0);
        is_csr   = (CHECK_OPCODE[6:0] == OP_SYSTEM) && (CHECK_OPCODE[9:7] != 3'd0);
        wb_mask  = WB_VALID ? (32'd1 << WB_RD) : 32'd0;
        set_mask = (valid && (CHECK_RD != 5'd0)) ? (32'd1 << CHECK_RD) : 32'd0;
        eff      = pending & ~wb_mask;
        eff[0]   = 1'b0;
        eff_csr  = csr_pending && !WB_CSR_VALID;
        hazard   = valid && (eff[CHECK_RS1] || eff[CHECK_RS2] || eff[CHECK_RD] ||
                             (CSR_TRACK && is_csr && eff_csr));
        STALL    = hazard && !FLUSH && !MEM_WAIT;
    end

    // Scoreboard update: flush clears all, otherwise retire writebacks and
    // record destinations of issued instructions (set wins over clear)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending     <= 32'd0;
            csr_pending <= 1'b0;
        end else if (FLUSH) begin
            pending     <= 32'd0;
            csr_pending <= 1'b0;
        end else if (MEM_WAIT || hazard) begin
            pending     <= eff;
            csr_pending <= eff_csr;
        end else begin
            pending     <= (eff | set_mask) & 32'hFFFF_FFFE;
            csr_pending <= eff_csr || (CSR_TRACK && valid && is_csr);
        end
    end

    // Issue slot: flush zeroes, memory wait holds, hazard inserts a bubble,
    // otherwise the checked instruction is registered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N || FLUSH) begin
            vld_p1    <= 1'b0;
            pc_p1     <= 32'd0;
            opcode_p1 <= 17'd0;
            rd_p1     <= 5'd0;
            rs1_p1    <= 5'd0;
            rs2_p1    <= 5'd0;
            csr_p1    <= 12'd0;
            imm_p1    <= 32'd0;
        end else if (MEM_WAIT) begin
            vld_p1    <= vld_p1;
        end else if (hazard) begin
            vld_p1    <= 1'b0;
            pc_p1     <= 32'd0;
            opcode_p1 <= 17'd0;
            rd_p1     <= 5'd0;
            rs1_p1    <= 5'd0;
            rs2_p1    <= 5'd0;
            csr_p1    <= 12'd0;
            imm_p1    <= 32'd0;
        end else begin
            vld_p1    <= valid;
            pc_p1     <= CHECK_PC;
            opcode_p1 <= CHECK_OPCODE;
            rd_p1     <= CHECK_RD;
            rs1_p1    <= CHECK_RS1;
            rs2_p1    <= CHECK_RS2;
            csr_p1    <= CHECK_CSR;
            imm_p1    <= CHECK_IMM;
        end
    end

    assign SCHEDULE1_VALID  = vld_p1;
    assign SCHEDULE1_PC     = pc_p1;
    assign SCHEDULE1_OPCODE = opcode_p1;
    assign SCHEDULE1_RD     = rd_p1;
    assign SCHEDULE1_RS1    = rs1_p1;
    assign SCHEDULE1_RS2    = rs2_p1;
    assign SCHEDULE1_CSR    = csr_p1;
    assign SCHEDULE1_IMM    = imm_p1;

endmodule

// File: tb/tb_schedule_1.sv
// Directed testbench for schedule_1: independent stream, RAW/WAW/CSR stalls,
// flush, memory wait and asynchronous reset. A second instance with CSR
// tracking disabled shares the inputs.
module tb_schedule_1;

    localparam logic [16:0] OP_ADD   = 17'h00033;
    localparam logic [16:0] OP_CSRRW = 17'h000F3;

    logic        CLK;
    logic        RST_N;
    logic        FLUSH;
    logic        MEM_WAIT;
    logic [31:0] CHECK_PC;
    logic [16:0] CHECK_OPCODE;
    logic [4:0]  CHECK_RD;
    logic [4:0]  CHECK_RS1;
    logic [4:0]  CHECK_RS2;
    logic [11:0] CHECK_CSR;
    logic [31:0] CHECK_IMM;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic        WB_CSR_VALID;

    logic        STALL;
    logic        SCHEDULE1_VALID;
    logic [31:0] SCHEDULE1_PC;
    logic [16:0] SCHEDULE1_OPCODE;
    logic [4:0]  SCHEDULE1_RD;
    logic [4:0]  SCHEDULE1_RS1;
    logic [4:0]  SCHEDULE1_RS2;
    logic [11:0] SCHEDULE1_CSR;
    logic [31:0] SCHEDULE1_IMM;

    logic        n_stall;
    logic        n_valid;
    logic [31:0] n_pc;
    logic [16:0] n_opcode;
    logic [4:0]  n_rd;
    logic [4:0]  n_rs1;
    logic [4:0]  n_rs2;
    logic [11:0] n_csr;
    logic [31:0] n_imm;

    int checks = 0;
    int errors = 0;

    schedule_1 #(.CSR_TRACK(1'b1)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .CHECK_PC(CHECK_PC), .CHECK_OPCODE(CHECK_OPCODE), .CHECK_RD(CHECK_RD),
        .CHECK_RS1(CHECK_RS1), .CHECK_RS2(CHECK_RS2), .CHECK_CSR(CHECK_CSR),
        .CHECK_IMM(CHECK_IMM), .WB_VALID(WB_VALID), .WB_RD(WB_RD),
        .WB_CSR_VALID(WB_CSR_VALID), .STALL(STALL),
        .SCHEDULE1_VALID(SCHEDULE1_VALID), .SCHEDULE1_PC(SCHEDULE1_PC),
        .SCHEDULE1_OPCODE(SCHEDULE1_OPCODE), .SCHEDULE1_RD(SCHEDULE1_RD),
        .SCHEDULE1_RS1(SCHEDULE1_RS1), .SCHEDULE1_RS2(SCHEDULE1_RS2),
        .SCHEDULE1_CSR(SCHEDULE1_CSR), .SCHEDULE1_IMM(SCHEDULE1_IMM)
    );

    schedule_1 #(.CSR_TRACK(1'b0)) u_dut_nocsr (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .CHECK_PC(CHECK_PC), .CHECK_OPCODE(CHECK_OPCODE), .CHECK_RD(CHECK_RD),
        .CHECK_RS1(CHECK_RS1), .CHECK_RS2(CHECK_RS2), .CHECK_CSR(CHECK_CSR),
        .CHECK_IMM(CHECK_IMM), .WB_VALID(WB_VALID), .WB_RD(WB_RD),
        .WB_CSR_VALID(WB_CSR_VALID), .STALL(n_stall),
        .SCHEDULE1_VALID(n_valid), .SCHEDULE1_PC(n_pc),
        .SCHEDULE1_OPCODE(n_opcode), .SCHEDULE1_RD(n_rd),
        .SCHEDULE1_RS1(n_rs1), .SCHEDULE1_RS2(n_rs2),
        .SCHEDULE1_CSR(n_csr), .SCHEDULE1_IMM(n_imm)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [16:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [11:0] csr,
                             input logic [31:0] imm);
        CHECK_PC     = pc;
        CHECK_OPCODE = op;
        CHECK_RD     = rd;
        CHECK_RS1    = rs1;
        CHECK_RS2    = rs2;
        CHECK_CSR    = csr;
        CHECK_IMM    = imm;
    endtask

    task automatic bubble();
        set_instr(32'd0, 17'd0, 5'd0, 5'd0, 5'd0, 12'd0, 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, SCHEDULE1_VALID}, 64'd0);
        chk({tag, "_pc"}, {32'd0, SCHEDULE1_PC}, 64'd0);
        chk({tag, "_rd"}, {59'd0, SCHEDULE1_RD}, 64'd0);
        chk({tag, "_op"}, {47'd0, SCHEDULE1_OPCODE}, 64'd0);
    endtask

    initial begin
        RST_N = 1'b0; FLUSH = 1'b0; MEM_WAIT = 1'b0;
        WB_VALID = 1'b0; WB_RD = 5'd0; WB_CSR_VALID = 1'b0;
        bubble();
        #12;
        chk_zero_outputs("reset");
        chk("reset_stall", {63'd0, STALL}, 64'd0);
        step();
        RST_N = 1'b1;
        step();

        // Independent stream rd = 1..4, one per cycle, 1-cycle latency
        for (int i = 1; i <= 4; i++) begin
            set_instr(32'h1000 + 32'(i * 4), OP_ADD, 5'(i), 5'd0, 5'd0, 12'd0, 32'(i));
            #1 chk("stream_stall", {63'd0, STALL}, 64'd0);
            step();
            chk("stream_rd", {59'd0, SCHEDULE1_RD}, 64'(i));
            chk("stream_pc", {32'd0, SCHEDULE1_PC}, 64'(32'h1000 + i * 4));
            chk("stream_valid", {63'd0, SCHEDULE1_VALID}, 64'd1);
        end
        // Scoreboard now 0x1E: rs1 = 4 hazards, rs1 = 5 does not
        set_instr(32'h2000, OP_ADD, 5'd0, 5'd4, 5'd0, 12'd0, 32'd0);
        #1 chk("pend_bit4", {63'd0, STALL}, 64'd1);
        set_instr(32'h2000, OP_ADD, 5'd0, 5'd5, 5'd0, 12'd0, 32'd0);
        #1 chk("pend_bit5", {63'd0, STALL}, 64'd0);
        bubble();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        chk_zero_outputs("flush1");

        // RAW on x5, resolved by a same-cycle writeback
        set_instr(32'h100, OP_ADD, 5'd5, 5'd0, 5'd0, 12'd0, 32'h11);
        step();
        chk("raw_issue_rd", {59'd0, SCHEDULE1_RD}, 64'd5);
        set_instr(32'h104, OP_ADD, 5'd6, 5'd5, 5'd0, 12'd0, 32'h22);
        #1 chk("raw_stall", {63'd0, STALL}, 64'd1);
        step();
        chk("raw_bubble_valid", {63'd0, SCHEDULE1_VALID}, 64'd0);
        chk("raw_bubble_pc", {32'd0, SCHEDULE1_PC}, 64'd0);
        chk("raw_still_stall", {63'd0, STALL}, 64'd1);
        WB_VALID = 1'b1; WB_RD = 5'd5;
        #1 chk("raw_wb_bypass", {63'd0, STALL}, 64'd0);
        step();
        WB_VALID = 1'b0;
        chk("raw_issue_valid", {63'd0, SCHEDULE1_VALID}, 64'd1);
        chk("raw_issue_pc", {32'd0, SCHEDULE1_PC}, 64'h104);
        chk("raw_issue_imm", {32'd0, SCHEDULE1_IMM}, 64'h22);
        set_instr(32'h108, OP_ADD, 5'd0, 5'd5, 5'd0, 12'd0, 32'd0);
        #1 chk("raw_x5_retired", {63'd0, STALL}, 64'd0);
        bubble();
        step();

        // WAW on x7; writeback and re-set land on the same edge, set wins
        set_instr(32'h200, OP_ADD, 5'd7, 5'd0, 5'd0, 12'd0, 32'd0);
        step();
        set_instr(32'h204, OP_ADD, 5'd7, 5'd0, 5'd0, 12'd0, 32'd0);
        #1 chk("waw_stall", {63'd0, STALL}, 64'd1);
        step();
        chk("waw_bubble", {63'd0, SCHEDULE1_VALID}, 64'd0);
        WB_VALID = 1'b1; WB_RD = 5'd7;
        #1 chk("waw_wb_bypass", {63'd0, STALL}, 64'd0);
        step();
        WB_VALID = 1'b0;
        chk("waw_issue_pc", {32'd0, SCHEDULE1_PC}, 64'h204);
        chk("waw_issue_rd", {59'd0, SCHEDULE1_RD}, 64'd7);
        set_instr(32'h208, OP_ADD, 5'd0, 5'd0, 5'd7, 12'd0, 32'd0);
        #1 chk("waw_x7_reset", {63'd0, STALL}, 64'd1);
        bubble();
        step();

        // CSR slot hazard; untracked instance never stalls
        set_instr(32'h300, OP_CSRRW, 5'd0, 5'd0, 5'd0, 12'h305, 32'd0);
        #1 chk("csr_first_stall", {63'd0, STALL}, 64'd0);
        step();
        chk("csr_first_csr", {52'd0, SCHEDULE1_CSR}, 64'h305);
        set_instr(32'h304, OP_CSRRW, 5'd0, 5'd0, 5'd0, 12'h341, 32'd0);
        #1 chk("csr_second_stall", {63'd0, STALL}, 64'd1);
        chk("csr_untracked_stall", {63'd0, n_stall}, 64'd0);
        step();
        chk("csr_bubble", {63'd0, SCHEDULE1_VALID}, 64'd0);
        WB_CSR_VALID = 1'b1;
        #1 chk("csr_wb_bypass", {63'd0, STALL}, 64'd0);
        step();
        WB_CSR_VALID = 1'b0;
        chk("csr_issue_pc", {32'd0, SCHEDULE1_PC}, 64'h304);
        chk("csr_issue_csr", {52'd0, SCHEDULE1_CSR}, 64'h341);
        bubble();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;

        // Fill x1..x31, then flush over a live hazard
        for (int r = 1; r < 32; r++) begin
            set_instr(32'h4000 + 32'(r), OP_ADD, 5'(r), 5'd0, 5'd0, 12'd0, 32'd0);
            step();
        end
        chk("fill_last_rd", {59'd0, SCHEDULE1_RD}, 64'd31);
        set_instr(32'h5000, OP_ADD, 5'd0, 5'd3, 5'd0, 12'd0, 32'd0);
        #1 chk("full_hazard", {63'd0, STALL}, 64'd1);
        FLUSH = 1'b1;
        WB_VALID = 1'b1; WB_RD = 5'd9;
        #1 chk("flush_masks_stall", {63'd0, STALL}, 64'd0);
        step();
        FLUSH = 1'b0; WB_VALID = 1'b0;
        chk_zero_outputs("flush2");
        set_instr(32'h5004, OP_ADD, 5'd17, 5'd3, 5'd31, 12'd0, 32'd0);
        #1 chk("flush_cleared_regs", {63'd0, STALL}, 64'd0);
        set_instr(32'h5008, OP_CSRRW, 5'd0, 5'd0, 5'd0, 12'h300, 32'd0);
        #1 chk("flush_cleared_csr", {63'd0, STALL}, 64'd0);
        bubble();
        step();

        // Memory wait: outputs frozen, writeback retires x3, no new bits
        set_instr(32'h600, OP_ADD, 5'd3, 5'd0, 5'd0, 12'd0, 32'h33);
        step();
        set_instr(32'h604, OP_ADD, 5'd9, 5'd0, 5'd0, 12'd0, 32'd0);
        MEM_WAIT = 1'b1;
        for (int c = 0; c < 3; c++) begin
            WB_VALID = (c == 1); WB_RD = 5'd3;
            step();
            chk("mw_hold_pc", {32'd0, SCHEDULE1_PC}, 64'h600);
            chk("mw_hold_rd", {59'd0, SCHEDULE1_RD}, 64'd3);
        end
        MEM_WAIT = 1'b0; WB_VALID = 1'b0;
        set_instr(32'h608, OP_ADD, 5'd0, 5'd3, 5'd0, 12'd0, 32'd0);
        #1 chk("mw_x3_retired", {63'd0, STALL}, 64'd0);
        set_instr(32'h608, OP_ADD, 5'd0, 5'd9, 5'd0, 12'd0, 32'd0);
        #1 chk("mw_no_new_bits", {63'd0, STALL}, 64'd0);
        bubble();
        step();

        // Asynchronous reset in the middle of a stall
        set_instr(32'h700, OP_ADD, 5'd10, 5'd0, 5'd0, 12'd0, 32'd0);
        step();
        set_instr(32'h704, OP_ADD, 5'd0, 5'd10, 5'd0, 12'd0, 32'd0);
        #1 chk("pre_reset_stall", {63'd0, STALL}, 64'd1);
        RST_N = 1'b0;
        #1;
        chk("async_reset_stall", {63'd0, STALL}, 64'd0);
        chk_zero_outputs("async_reset");
        step();
        RST_N = 1'b1;
        #1 chk("post_reset_clear", {63'd0, STALL}, 64'd0);
        bubble();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
